multi_read_fifo: RTL
====================

Name: multi_read_fifo

Overview:
- Single-writer, N-reader circular buffer for weight/input data feeding the convolution PEs.
- Every pushed word stays resident until all readers have popped it.
- Parametrised successor of the fixed 16-deep dual-reader FIFO. Generalises depth, width and reader count.
- Adds per-reader occupancy counts, almost-full, and sticky overflow/underflow flags. Uses wrap-bit pointers instead of separate round trackers.

Parameters:
DataWidth, 32, width of each stored word
AddrWidth, 4, pointer index width; Depth = 2**AddrWidth (derived localparam, not overridable)
NumReaders, 2, number of independent read ports (1..8)
AlmostFullLvl, 12, almost_full asserts when max reader occupancy >= this value (1..Depth)

Ports:
clk  input  1  clock, rising edge
aclr  input  1  asynchronous active-low reset
push  input  1  write DataIn at tail when not full
DataIn  input  DataWidth  write data
pop  input  NumReaders  bit i advances reader i head when reader i not empty
DataOut  output  NumReaders*DataWidth  slice i = word at reader i head (show-ahead)
Empty  output  NumReaders  bit i = reader i has nothing unread
Full  output  1  some reader lags by Depth words
AlmostFull  output  1  max occupancy >= AlmostFullLvl
Count  output  NumReaders*(AddrWidth+1)  slice i = unread words for reader i, 0..Depth
SlotReady  output  NumReaders*Depth  slice i bit k = slot k unread by reader i
Valid  output  Depth  bit k = slot k unread by any reader (OR over readers)
Overflow  output  1  sticky: push attempted while Full
Underflow  output  NumReaders  sticky bit i: pop[i] attempted while Empty[i]

Behaviour:
- Reset (aclr low, asynchronous):
  - Write and read pointers cleared to 0.
  - Storage cleared to 0, so DataOut = 0.
  - Empty = all ones; Full = 0; AlmostFull = 0; Count = 0; SlotReady = 0; Valid = 0; Overflow = 0; Underflow = 0.
- Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Pointers are AddrWidth+1 bits; the MSB is the wrap bit. Occupancy is computed per reader as occ_i = (wptr - rptr_i), modulo 2**(AddrWidth+1).
- Full = OR over readers of (occ_i == Depth). Empty[i] = (occ_i == 0).
- Push accepted iff push & ~Full at the clock edge:
  - mem[wptr[AddrWidth-1:0]] <= DataIn.
  - wptr increments and wraps naturally.
- Pop[i] accepted iff pop[i] & ~Empty[i]: rptr_i increments. Readers are fully independent; any subset may pop in the same cycle.
- Simultaneous push and pop:
  - Both evaluated against pre-edge flags.
  - Push while Full is rejected even if the lagging reader pops in the same cycle (no pass-through).
  - Pop while Empty[i] is rejected even if a push occurs in the same cycle.
  - Accepted push+pop on reader i leaves Count_i unchanged.
- Latency:
  - Pushed word is visible on DataOut slice i and clears Empty[i] the cycle after the push edge.
  - DataOut is a combinational read of mem at rptr_i, i.e. first-word-fall-through.
  - DataOut slice i is don't-care when Empty[i] (holds stale memory contents).
- SlotReady slice i bit k = 1 iff slot k lies in the half-open range [rptr_i, wptr) mod Depth. When occ_i == Depth, all bits are 1.
- Count, Empty, Full, AlmostFull, SlotReady and Valid are combinational from registered pointers; they have no direct path from push or pop.
- Overflow and Underflow set on the rejected attempt and clear only on reset. The rejected operation has no other effect.
- Arithmetic: all pointer math is unsigned, AddrWidth+1 bits, wrapping modulo 2**(AddrWidth+1). No saturation is needed.

Decomposition:
- Shared package (conv_pkg): default DataWidth/AddrWidth constants and a clog2 function for the Count width.
- Sub-module fifo_read_port, instantiated NumReaders times via generate. Each instance contains:
  - read pointer register;
  - occupancy subtractor;
  - Empty/full-contribution logic;
  - SlotReady mask decode;
  - Underflow sticky bit.
- Top level owns storage, write pointer, Full/AlmostFull/Valid reduction and Overflow.

Test Plan:
- Reset, then push 0xA0..0xA4 (5 words), no pops -> Count = 5 for both readers, Empty = 2'b00, SlotReady = 0x001F per reader, DataOut slices both = 0xA0.
- Reader 0 pops 5 times, reader 1 idle -> Empty = 2'b01, Count = {5,0}, Valid still 0x001F, DataOut slice 1 = 0xA0.
- Push 16 words with reader 1 never popping -> Full = 1 at Count_1 = 16, AlmostFull asserted from Count_1 = 12. A 17th push sets Overflow; storage and pointers are unchanged.
- Fill to 16, then same cycle push 0xFF and pop[1] -> push rejected, Count_1 = 15, Full = 0 next cycle, Overflow = 1.
- Wrap-around: 40 interleaved push/pop pairs on both readers -> Count stays 1, DataOut tracks the last push each cycle, wrap bit toggles after 16 and 32 pushes.
- Pop[0] while Empty[0], then assert aclr asynchronously mid-cycle -> Underflow = 2'b01 before reset. All outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution front-end buffers.
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  // Smallest n such that 2**n >= value; sizes the per-reader Count field.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/fifo_read_port.sv
// One independent read port of the multi-reader FIFO: read pointer,
// occupancy, empty/full contribution, slot-ready mask and sticky underflow.
module fifo_read_port
  import conv_pkg::*;
#(
  parameter  int AddrWidth = DEF_ADDR_WIDTH,
  localparam int Depth     = 2 ** AddrWidth,
  localparam int PtrW      = AddrWidth + 1
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             pop,
  input  logic [PtrW-1:0]  wptr,
  output logic [PtrW-1:0]  rptr,
  output logic [PtrW-1:0]  occ,
  output logic             empty,
  output logic             full_hit,
  output logic [Depth-1:0] slot_ready,
  output logic             underflow
);

  logic pop_acc;

  // Occupancy from wrap-bit pointers; modulo arithmetic handles the wrap.
  always_comb begin
    occ      = wptr - rptr;
    empty    = (occ == '0);
    full_hit = (occ == PtrW'(Depth));
    pop_acc  = pop & ~empty;
  end

  // Read pointer advances only on an accepted pop.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      rptr <= '0;
    end else if (pop_acc) begin
      rptr <= rptr + PtrW'(1);
    end
  end

  // Sticky record of any pop attempted against an empty view.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      underflow <= 1'b0;
    end else if (pop & empty) begin
      underflow <= 1'b1;
    end
  end

  // Slot k is unread when its distance ahead of the head is below occupancy;
  // this covers the full case (all ones) without special handling.
  always_comb begin
    logic [AddrWidth-1:0] off;
    slot_ready = '0;
    off        = '0;
    for (int k = 0; k < Depth; k++) begin
      off           = AddrWidth'(k) - rptr[AddrWidth-1:0];
      slot_ready[k] = ({1'b0, off} < occ);
    end
  end

endmodule

// File: rtl/multi_read_fifo.sv
// Single-writer, N-reader circular buffer; a word stays resident until
// every reader has popped it. Storage, write side and flag reductions.
module multi_read_fifo
  import conv_pkg::*;
#(
  parameter  int DataWidth     = DEF_DATA_WIDTH,
  parameter  int AddrWidth     = DEF_ADDR_WIDTH,
  parameter  int NumReaders    = 2,
  parameter  int AlmostFullLvl = 12,
  localparam int Depth         = 2 ** AddrWidth,
  localparam int PtrW          = AddrWidth + 1
) (
  input  logic                            clk,
  input  logic                            aclr,
  input  logic                            push,
  input  logic [DataWidth-1:0]            DataIn,
  input  logic [NumReaders-1:0]           pop,
  output logic [NumReaders*DataWidth-1:0] DataOut,
  output logic [NumReaders-1:0]           Empty,
  output logic                            Full,
  output logic                            AlmostFull,
  output logic [NumReaders*PtrW-1:0]      Count,
  output logic [NumReaders*Depth-1:0]     SlotReady,
  output logic [Depth-1:0]                Valid,
  output logic                            Overflow,
  output logic [NumReaders-1:0]           Underflow
);

  localparam int CountW = clog2(Depth + 1);

  logic [DataWidth-1:0]  mem [Depth];
  logic [PtrW-1:0]       wptr;
  logic [PtrW-1:0]       rptr [NumReaders];
  logic [PtrW-1:0]       occ  [NumReaders];
  logic [NumReaders-1:0] full_hit;
  logic [NumReaders-1:0] af_hit;
  logic                  push_acc;

  assign push_acc = push & ~Full;

  for (genvar i = 0; i < NumReaders; i++) begin : g_rd
    fifo_read_port #(
      .AddrWidth (AddrWidth)
    ) u_port (
      .clk        (clk),
      .aclr       (aclr),
      .pop        (pop[i]),
      .wptr       (wptr),
      .rptr       (rptr[i]),
      .occ        (occ[i]),
      .empty      (Empty[i]),
      .full_hit   (full_hit[i]),
      .slot_ready (SlotReady[i*Depth +: Depth]),
      .underflow  (Underflow[i])
    );

    assign DataOut[i*DataWidth +: DataWidth] = mem[rptr[i][AddrWidth-1:0]];
    assign Count[i*CountW +: CountW]         = CountW'(occ[i]);
    assign af_hit[i]                         = (occ[i] >= PtrW'(AlmostFullLvl));
  end

  assign Full       = |full_hit;
  assign AlmostFull = |af_hit;

  // A slot is resident while any reader still has it unread.
  always_comb begin
    Valid = '0;
    for (int i = 0; i < NumReaders; i++) begin
      Valid = Valid | SlotReady[i*Depth +: Depth];
    end
  end

  // Storage write at the tail; cleared on reset so DataOut reads zero.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int k = 0; k < Depth; k++) begin
        mem[k] <= '0;
      end
    end else if (push_acc) begin
      mem[wptr[AddrWidth-1:0]] <= DataIn;
    end
  end

  // Write pointer with wrap bit; no pass-through when the slowest reader is full.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wptr <= '0;
    end else if (push_acc) begin
      wptr <= wptr + PtrW'(1);
    end
  end

  // Sticky record of any push attempted while full.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      Overflow <= 1'b0;
    end else if (push & Full) begin
      Overflow <= 1'b1;
    end
  end

endmodule
